// File: rtl/lcd_rgb_timing_gen_pkg.sv
// lcd_pkg: 480x272 panel timing defaults, FSM encoding and RGB565 to RGB888 expansion.
package lcd_pkg;
    localparam int DEF_H_SYNC   = 41;
    localparam int DEF_H_BP     = 2;
    localparam int DEF_H_ACTIVE = 480;
    localparam int DEF_H_FP     = 2;
    localparam int DEF_V_SYNC   = 10;
    localparam int DEF_V_BP     = 2;
    localparam int DEF_V_ACTIVE = 272;
    localparam int DEF_V_FP     = 2;
    localparam int DEF_H_TOTAL  = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_V_TOTAL  = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;

    typedef enum logic {IDLE, RUN} state_t;

    // Replicating the top bits keeps full-scale 565 values at full-scale 888.
    function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] d);
        return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
    endfunction
endpackage

// File: rtl/lcd_rgb_timing_gen_if.sv
// lcd_rgb_timing_gen_if: showahead FIFO read port between the read master's buffer and the timing generator.
interface lcd_rgb_timing_gen_if;
    logic [15:0] pix_data;
    logic        pix_available;
    logic        pix_read;
    modport master (input pix_data, pix_available, output pix_read);
    modport slave  (output pix_data, pix_available, input pix_read);
endinterface

// File: rtl/lcd_rgb_timing_gen_sync_counter.sv
// lcd_sync_counter: one timing axis walking through sync, back porch, active and front porch regions.
module lcd_sync_counter #(
    parameter int SYNC   = 1,
    parameter int BP     = 1,
    parameter int ACTIVE = 1,
    parameter int FP     = 1,
    localparam int TOTAL = SYNC + BP + ACTIVE + FP,
    localparam int W     = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         in_sync,
    output logic         in_active,
    output logic         last
);
    localparam logic [W-1:0] SYNC_END = W'(SYNC);
    localparam logic [W-1:0] ACT_LO   = W'(SYNC + BP);
    localparam logic [W-1:0] ACT_HI   = W'(SYNC + BP + ACTIVE);
    localparam logic [W-1:0] LAST     = W'(TOTAL - 1);

    assign in_sync   = cnt < SYNC_END;
    assign in_active = cnt >= ACT_LO && cnt < ACT_HI;
    assign last      = cnt == LAST;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else if (inc) cnt <= last ? '0 : cnt + 1'b1;
endmodule

// File: rtl/lcd_rgb_timing_gen.sv
// lcd_rgb_timing_gen: parallel RGB panel HSYNC/VSYNC/DE generator popping RGB565 pixels from a showahead FIFO.
module lcd_rgb_timing_gen
    import lcd_pkg::*;
#(
    parameter int          H_SYNC        = DEF_H_SYNC,
    parameter int          H_BP          = DEF_H_BP,
    parameter int          H_ACTIVE      = DEF_H_ACTIVE,
    parameter int          H_FP          = DEF_H_FP,
    parameter int          V_SYNC        = DEF_V_SYNC,
    parameter int          V_BP          = DEF_V_BP,
    parameter int          V_ACTIVE      = DEF_V_ACTIVE,
    parameter int          V_FP          = DEF_V_FP,
    parameter bit          HS_POL        = 1'b0,
    parameter bit          VS_POL        = 1'b0,
    parameter logic [23:0] UNDERFLOW_RGB = 24'h0000FF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic                         underflow_clear,
    lcd_rgb_timing_gen_if.master         fifo,
    output logic                         frame_start,
    output logic                         frame_end,
    output logic                         underflow,
    output logic [15:0]                  underflow_count,
    output logic                         lcd_hsync,
    output logic                         lcd_vsync,
    output logic                         lcd_de,
    output logic [7:0]                   lcd_r,
    output logic [7:0]                   lcd_g,
    output logic [7:0]                   lcd_b
);
    localparam int HW = $clog2(H_SYNC + H_BP + H_ACTIVE + H_FP);
    localparam int VW = $clog2(V_SYNC + V_BP + V_ACTIVE + V_FP);
    localparam logic [HW-1:0] H_LAST_ACT = HW'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [VW-1:0] V_LAST_ACT = VW'(V_SYNC + V_BP + V_ACTIVE - 1);

    state_t state, state_nxt;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic run, boundary, fs_nxt, active, starve;
    logic h_sync, h_act, h_last, v_sync, v_act, v_last;

    assign run = state == RUN;

    lcd_sync_counter #(.SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP)) u_h (
        .clk, .reset_n, .inc(run), .cnt(hcnt), .in_sync(h_sync), .in_active(h_act), .last(h_last)
    );
    lcd_sync_counter #(.SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP)) u_v (
        .clk, .reset_n, .inc(run && h_last), .cnt(vcnt), .in_sync(v_sync), .in_active(v_act), .last(v_last)
    );

    assign active        = run && h_act && v_act;
    assign starve        = active && !fifo.pix_available;
    assign fifo.pix_read = active && fifo.pix_available;

    // Enable is only sampled in IDLE or at the frame wrap so frames are never cut short.
    always_comb begin
        boundary  = !run || (h_last && v_last);
        state_nxt = boundary ? (enable ? RUN : IDLE) : state;
        fs_nxt    = boundary && enable;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_start           <= 1'b0;
            frame_end             <= 1'b0;
            lcd_hsync             <= !HS_POL;
            lcd_vsync             <= !VS_POL;
            lcd_de                <= 1'b0;
            {lcd_r, lcd_g, lcd_b} <= '0;
            underflow             <= 1'b0;
            underflow_count       <= '0;
        end else begin
            frame_start           <= fs_nxt;
            frame_end             <= active && hcnt == H_LAST_ACT && vcnt == V_LAST_ACT;
            lcd_hsync             <= (run && h_sync) ? HS_POL : !HS_POL;
            lcd_vsync             <= (run && v_sync) ? VS_POL : !VS_POL;
            lcd_de                <= active;
            {lcd_r, lcd_g, lcd_b} <= !active ? '0 : fifo.pix_available ? rgb565_to_rgb888(fifo.pix_data) : UNDERFLOW_RGB;
            underflow             <= !underflow_clear && (underflow || starve);
            underflow_count       <= underflow_clear ? '0 :
                                     (starve && underflow_count != 16'hFFFF) ? underflow_count + 1'b1 : underflow_count;
        end
    end
endmodule

// File: tb/tb_lcd_rgb_timing_gen.sv
// tb_lcd_rgb_timing_gen: random and directed stimulus against a frame-position reference model of the panel timing.
module tb_lcd_rgb_timing_gen;
    localparam int HS = 2, HB = 1, HA = 4, HF = 1;
    localparam int VS = 1, VB = 1, VA = 2, VF = 1;
    localparam int HT = HS + HB + HA + HF;
    localparam int FT = HT * (VS + VB + VA + VF);
    localparam bit HS_POL = 1'b0, VS_POL = 1'b0;
    localparam logic [23:0] UF_RGB = 24'h0000FF;

    logic clk = 1'b0;
    logic reset_n, enable, underflow_clear;
    logic frame_start, frame_end, underflow, lcd_hsync, lcd_vsync, lcd_de;
    logic [15:0] underflow_count;
    logic [7:0] lcd_r, lcd_g, lcd_b;

    lcd_rgb_timing_gen_if fifo ();

    lcd_rgb_timing_gen #(
        .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .UNDERFLOW_RGB(UF_RGB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .underflow_clear(underflow_clear),
        .fifo(fifo), .frame_start(frame_start), .frame_end(frame_end),
        .underflow(underflow), .underflow_count(underflow_count),
        .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_de(lcd_de),
        .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b)
    );

    always #5 clk = ~clk;

    int nvec = 0, nerr = 0;
    int pops, des, fss;
    logic [15:0] q[$];
    bit m_run;
    int m_p;
    logic e_hs, e_vs, e_de, e_fs, e_fe, e_uf;
    logic [23:0] e_rgb;
    logic [15:0] e_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] to888(input logic [15:0] p);
        int r, g, b;
        r = int'(p) >> 11;
        g = (int'(p) >> 5) & 63;
        b = int'(p) & 31;
        return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
    endfunction

    task automatic model_reset();
        m_run = 0; m_p = 0;
        e_hs = !HS_POL; e_vs = !VS_POL; e_de = 0; e_rgb = '0;
        e_fs = 0; e_fe = 0; e_uf = 0; e_cnt = '0;
    endtask

    task automatic check_outputs();
        check("hsync", lcd_hsync, e_hs);
        check("vsync", lcd_vsync, e_vs);
        check("de", lcd_de, e_de);
        check("rgb", {lcd_r, lcd_g, lcd_b}, e_rgb);
        check("frame_start", frame_start, e_fs);
        check("frame_end", frame_end, e_fe);
        check("underflow", underflow, e_uf);
        check("underflow_count", underflow_count, e_cnt);
    endtask

    // One pixel clock, entered and left at a falling edge.
    task automatic step(input bit en, input int hole_at, input int clr_at, input bit rnd);
        int h, v, idx;
        bit act, av, pop, clr, wrap;
        logic [15:0] d;
        h = m_p % HT;
        v = m_p / HT;
        act = m_run && h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA;
        idx = (v - VS - VB) * HA + (h - HS - HB);
        av = q.size() > 0 && !(act && idx == hole_at) && !(rnd && $urandom_range(0, 5) == 0);
        clr = (act && idx == clr_at) || (rnd && $urandom_range(0, 30) == 0);
        d = q.size() > 0 ? q[0] : 16'($urandom);
        enable = en; underflow_clear = clr; fifo.pix_available = av; fifo.pix_data = d;
        #1;
        pop = act && av;
        check("pix_read", fifo.pix_read, pop);
        if (fifo.pix_read) pops++;
        wrap = m_p == FT - 1;
        e_hs = (m_run && h < HS) ? HS_POL : !HS_POL;
        e_vs = (m_run && v < VS) ? VS_POL : !VS_POL;
        e_de = act;
        e_rgb = !act ? 24'h0 : av ? to888(d) : UF_RGB;
        e_fe = act && idx == HA * VA - 1;
        e_fs = en && (!m_run || wrap);
        if (clr) begin
            e_uf = 0; e_cnt = '0;
        end else if (act && !av) begin
            e_uf = 1; e_cnt = (e_cnt == 16'hFFFF) ? e_cnt : e_cnt + 16'd1;
        end
        m_p = (m_run && !wrap) ? m_p + 1 : 0;
        m_run = m_run ? (!wrap || en) : en;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        @(negedge clk);
        check_outputs();
        if (lcd_de) des++;
        if (frame_start) fss++;
    endtask

    task automatic fill(input int n);
        repeat (n) q.push_back(16'($urandom));
    endtask

    task automatic zero_counts();
        pops = 0; des = 0; fss = 0;
    endtask

    initial begin
        reset_n = 0; enable = 0; underflow_clear = 0;
        fifo.pix_available = 0; fifo.pix_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        check("reset_pix_read", fifo.pix_read, 0);
        reset_n = 1;

        // First frame with pre-filled FIFO and known colours
        q = '{16'hF800, 16'h07E0, 16'h001F, 16'h8410};
        fill(4);
        zero_counts();
        step(1, -1, -1, 0);
        check("fs_after_enable", frame_start, 1);
        repeat (FT - 1) step(1, -1, -1, 0);
        check("s1_pops", pops, 8);
        check("s1_des", des, 8);
        check("s1_frame_starts", fss, 1);

        // Third pixel of the first active line starved
        fill(8);
        zero_counts();
        repeat (FT) step(1, 2, -1, 0);
        check("s3_pops", pops, 7);
        check("s3_des", des, 8);
        check("s3_underflow", underflow, 1);
        check("s3_count", underflow_count, 1);
        check("s3_left_in_fifo", q.size(), 1);

        // Enable dropped mid-frame
        q.delete();
        fill(8);
        zero_counts();
        repeat (15) step(1, -1, -1, 0);
        repeat (FT + 20) step(0, -1, -1, 0);
        check("s4_des", des, 8);
        check("s4_pops", pops, 8);
        check("s4_frame_starts", fss, 1);
        check("s4_idle_hsync", lcd_hsync, !HS_POL);
        check("s4_idle_vsync", lcd_vsync, !VS_POL);

        // Empty FIFO, clear coincident with the fourth underflow
        q.delete();
        zero_counts();
        repeat (FT) step(1, -1, 3, 0);
        check("s5_underflow", underflow, 1);
        check("s5_count", underflow_count, 4);

        // Reset in the middle of an active line
        fill(8);
        repeat (23) step(1, -1, -1, 0);
        reset_n = 0;
        #1;
        model_reset();
        check_outputs();
        check("s6_reset_pix_read", fifo.pix_read, 0);
        enable = 1;
        repeat (2) @(negedge clk);
        check_outputs();
        reset_n = 1;
        q.delete();
        fill(8);
        zero_counts();
        step(1, -1, -1, 0);
        check("s6_fs_after_release", frame_start, 1);
        repeat (FT - 1) step(1, -1, -1, 0);
        check("s6_pops", pops, 8);
        check("s6_des", des, 8);

        // Random enable, starvation and clears
        repeat (400) begin
            if (q.size() < 6 && $urandom_range(0, 1) == 1) fill(1);
            step($urandom_range(0, 9) != 0, -1, -1, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
